tablero_score_ctrl: RTL and testbench

- Board-state and scoreboard datapath controller driven by the tic-tac-toe game FSM's strobe outputs.
- Owns the X/O occupancy registers fed back to the FSM as x/o, the move counter, and the X/O/tie score counters read by the 7-segment display logic.
- Enforces write legality, clear precedence and once-per-event score increments, independent of how long the FSM holds its level signals.

---
 rtl/tablero_score_ctrl_pkg.sv | 25 ++
 rtl/tablero_score_ctrl_score_counter.sv | 32 +++
 rtl/tablero_score_ctrl.sv | 152 +++++++++++++++
 tb/tb_tablero_score_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/tablero_score_ctrl_pkg.sv
// Shared types and constants for the tic-tac-toe board/score controller.
package tablero_pkg;

    localparam int CELLS         = 9;
    localparam int DEF_SCORE_W   = 4;
    localparam int DEF_MAX_SCORE = 9;

    typedef logic [3:0] cell_idx_t;

    typedef enum logic {
        PLAYER_X = 1'b0,
        PLAYER_O = 1'b1
    } player_t;

    // Callers only pass vectors already known to be one-hot.
    function automatic cell_idx_t onehot_to_idx(input logic [CELLS-1:0] v);
        cell_idx_t idx;
        idx = '0;
        for (int i = 0; i < CELLS; i++) begin
            if (v[i]) idx = cell_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/tablero_score_ctrl_score_counter.sv
// Single score digit: rising-edge detect on a level input, synchronous clear,
// saturating increment.
module score_counter
    import tablero_pkg::*;
#(
    parameter int SCORE_W   = DEF_SCORE_W,
    parameter int MAX_SCORE = DEF_MAX_SCORE
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               clear,
    input  logic               inc,
    output logic [SCORE_W-1:0] score
);

    logic prev;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            prev  <= 1'b0;
            score <= '0;
        end else begin
            // History always follows the input so an edge swallowed by clear is not replayed.
            prev <= inc;
            if (clear)
                score <= '0;
            else if (inc && !prev && score != SCORE_W'(MAX_SCORE))
                score <= score + 1'b1;
        end
    end

endmodule

// File: rtl/tablero_score_ctrl.sv
// Board occupancy, move counter and scoreboard for the tic-tac-toe game FSM.
// Optional move undo LIFO enabled by defining TABLERO_UNDO_EN.
module tablero_score_ctrl
    import tablero_pkg::*;
#(
    parameter int SCORE_W   = DEF_SCORE_W,
    parameter int MAX_SCORE = DEF_MAX_SCORE
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic [CELLS-1:0]   almacenar_x,
    input  logic [CELLS-1:0]   almacenar_o,
    input  logic               resetPosiciones,
    input  logic               resetScore,
    input  logic               inc_x_score,
    input  logic               inc_o_score,
    input  logic               inc_empate,
`ifdef TABLERO_UNDO_EN
    input  logic               deshacer,
`endif
    output logic [CELLS-1:0]   x,
    output logic [CELLS-1:0]   o,
    output logic [3:0]         move_count,
    output logic               board_full,
    output logic [SCORE_W-1:0] score_x,
    output logic [SCORE_W-1:0] score_o,
    output logic [SCORE_W-1:0] score_empate,
    output logic               illegal_move
);

    logic             req_x, req_o, req_any, one_hot, occupied, legal;
    logic [CELLS-1:0] req_vec;
    logic [CELLS-1:0] x_nxt, o_nxt;
    logic [3:0]       mc_nxt;
    logic             ill_nxt;

    assign req_x    = |almacenar_x;
    assign req_o    = |almacenar_o;
    assign req_any  = req_x | req_o;
    assign req_vec  = req_x ? almacenar_x : almacenar_o;
    assign one_hot  = (req_vec != '0) && ((req_vec & (req_vec - 1'b1)) == '0);
    assign occupied = |(req_vec & (x | o));
    assign legal    = (req_x ^ req_o) && one_hot && !occupied && (move_count != 4'(CELLS));

`ifdef TABLERO_UNDO_EN
    cell_idx_t stack_cell   [CELLS];
    player_t   stack_player [CELLS];
    logic [3:0] sp;
    logic [3:0] sp_top;
    cell_idx_t  top_cell;
    player_t    top_player;
    logic       push;

    assign sp_top     = sp - 1'b1;
    assign top_cell   = stack_cell[sp_top];
    assign top_player = stack_player[sp_top];
    assign push       = !resetPosiciones && !deshacer && req_any && legal;
`endif

    always_comb begin
        x_nxt   = x;
        o_nxt   = o;
        mc_nxt  = move_count;
        ill_nxt = 1'b0;
        if (resetPosiciones) begin
            x_nxt  = '0;
            o_nxt  = '0;
            mc_nxt = '0;
        end
`ifdef TABLERO_UNDO_EN
        else if (deshacer) begin
            if (sp != '0) begin
                if (top_player == PLAYER_O) o_nxt[top_cell] = 1'b0;
                else                        x_nxt[top_cell] = 1'b0;
                mc_nxt  = move_count - 1'b1;
                ill_nxt = req_any;
            end else begin
                ill_nxt = 1'b1;
            end
        end
`endif
        else if (req_any) begin
            if (legal) begin
                x_nxt  = x | almacenar_x;
                o_nxt  = o | almacenar_o;
                mc_nxt = move_count + 1'b1;
            end else begin
                ill_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            x            <= '0;
            o            <= '0;
            move_count   <= '0;
            board_full   <= 1'b0;
            illegal_move <= 1'b0;
        end else begin
            x            <= x_nxt;
            o            <= o_nxt;
            move_count   <= mc_nxt;
            board_full   <= (mc_nxt == 4'(CELLS));
            illegal_move <= ill_nxt;
        end
    end

`ifdef TABLERO_UNDO_EN
    always_ff @(posedge clk_100MHz) begin
        if (reset || resetPosiciones)
            sp <= '0;
        else if (deshacer) begin
            if (sp != '0) sp <= sp_top;
        end else if (push)
            sp <= sp + 1'b1;
    end

    // Entries above sp are don't-care, so the storage itself needs no reset.
    always_ff @(posedge clk_100MHz) begin
        if (push) begin
            stack_cell[sp]   <= onehot_to_idx(req_vec);
            stack_player[sp] <= req_x ? PLAYER_X : PLAYER_O;
        end
    end
`endif

    score_counter #(.SCORE_W(SCORE_W), .MAX_SCORE(MAX_SCORE)) u_score_x (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .clear      (resetScore),
        .inc        (inc_x_score),
        .score      (score_x)
    );

    score_counter #(.SCORE_W(SCORE_W), .MAX_SCORE(MAX_SCORE)) u_score_o (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .clear      (resetScore),
        .inc        (inc_o_score),
        .score      (score_o)
    );

    score_counter #(.SCORE_W(SCORE_W), .MAX_SCORE(MAX_SCORE)) u_score_empate (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .clear      (resetScore),
        .inc        (inc_empate),
        .score      (score_empate)
    );

endmodule

// File: tb/tb_tablero_score_ctrl.sv
// Directed bench for tablero_score_ctrl; undo steps run when TABLERO_UNDO_EN is defined.
module tb_tablero_score_ctrl;

    logic       clk_100MHz = 1'b0;
    logic       reset;
    logic [8:0] almacenar_x, almacenar_o;
    logic       resetPosiciones, resetScore;
    logic       inc_x_score, inc_o_score, inc_empate;
    logic       deshacer;
    logic [8:0] x, o;
    logic [3:0] move_count;
    logic       board_full;
    logic [3:0] score_x, score_o, score_empate;
    logic       illegal_move;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    tablero_score_ctrl dut (
        .clk_100MHz      (clk_100MHz),
        .reset           (reset),
        .almacenar_x     (almacenar_x),
        .almacenar_o     (almacenar_o),
        .resetPosiciones (resetPosiciones),
        .resetScore      (resetScore),
        .inc_x_score     (inc_x_score),
        .inc_o_score     (inc_o_score),
        .inc_empate      (inc_empate),
`ifdef TABLERO_UNDO_EN
        .deshacer        (deshacer),
`endif
        .x               (x),
        .o               (o),
        .move_count      (move_count),
        .board_full      (board_full),
        .score_x         (score_x),
        .score_o         (score_o),
        .score_empate    (score_empate),
        .illegal_move    (illegal_move)
    );

    task automatic step();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_cell(input logic [8:0] vx, input logic [8:0] vo);
        almacenar_x = vx;
        almacenar_o = vo;
        step();
        almacenar_x = '0;
        almacenar_o = '0;
    endtask

    initial begin
        reset = 1'b1;
        almacenar_x = '0; almacenar_o = '0;
        resetPosiciones = 1'b0; resetScore = 1'b0;
        inc_x_score = 1'b0; inc_o_score = 1'b0; inc_empate = 1'b0;
        deshacer = 1'b0;
        step(); step();
        reset = 1'b0;
        check("rst_x", 32'(x), 0);
        check("rst_o", 32'(o), 0);
        check("rst_mc", 32'(move_count), 0);
        check("rst_full", 32'(board_full), 0);
        check("rst_score_x", 32'(score_x), 0);
        check("rst_illegal", 32'(illegal_move), 0);

        // X takes the centre cell
        write_cell(9'h010, 9'h000);
        check("wr_x", 32'(x), 32'h010);
        check("wr_o", 32'(o), 0);
        check("wr_mc", 32'(move_count), 1);
        check("wr_illegal", 32'(illegal_move), 0);

        // occupied cell
        write_cell(9'h000, 9'h010);
        check("occ_o", 32'(o), 0);
        check("occ_mc", 32'(move_count), 1);
        check("occ_illegal", 32'(illegal_move), 1);
        step();
        check("occ_pulse_end", 32'(illegal_move), 0);

        // multi-hot
        write_cell(9'h003, 9'h000);
        check("mh_x", 32'(x), 32'h010);
        check("mh_illegal", 32'(illegal_move), 1);
        step();
        check("mh_pulse_end", 32'(illegal_move), 0);

        // both players at once
        write_cell(9'h001, 9'h002);
        check("both_x", 32'(x), 32'h010);
        check("both_o", 32'(o), 0);
        check("both_illegal", 32'(illegal_move), 1);
        step();

        // held level counts once, then a fresh edge
        inc_x_score = 1'b1;
        repeat (50) step();
        check("hold_score_x", 32'(score_x), 1);
        inc_x_score = 1'b0; step();
        inc_x_score = 1'b1; step();
        inc_x_score = 1'b0; step();
        check("edge2_score_x", 32'(score_x), 2);
        for (int i = 0; i < 10; i++) begin
            inc_x_score = 1'b1; step();
            inc_x_score = 1'b0; step();
        end
        check("sat_score_x", 32'(score_x), 9);

        for (int i = 0; i < 3; i++) begin
            inc_o_score = 1'b1; step();
            inc_o_score = 1'b0; step();
        end
        check("score_o_3", 32'(score_o), 3);
        resetScore  = 1'b1;
        inc_o_score = 1'b1;
        step();
        resetScore = 1'b0;
        check("clr_score_o", 32'(score_o), 0);
        check("clr_score_x", 32'(score_x), 0);
        repeat (5) step();
        check("clr_edge_consumed", 32'(score_o), 0);
        inc_o_score = 1'b0;
        step();

        // simultaneous edges on two counters
        inc_o_score = 1'b1; inc_empate = 1'b1;
        step();
        inc_o_score = 1'b0; inc_empate = 1'b0;
        check("sim_score_o", 32'(score_o), 1);
        check("sim_score_empate", 32'(score_empate), 1);
        check("sim_score_x", 32'(score_x), 0);

        // fill the rest of the board alternately
        write_cell(9'h000, 9'h001);
        write_cell(9'h002, 9'h000);
        write_cell(9'h000, 9'h004);
        write_cell(9'h008, 9'h000);
        write_cell(9'h000, 9'h020);
        write_cell(9'h040, 9'h000);
        write_cell(9'h000, 9'h080);
        check("fill8_full", 32'(board_full), 0);
        write_cell(9'h100, 9'h000);
        check("full_x", 32'(x), 32'h15A);
        check("full_o", 32'(o), 32'h0A5);
        check("full_mc", 32'(move_count), 9);
        check("full_flag", 32'(board_full), 1);
        check("full_illegal_pre", 32'(illegal_move), 0);
        write_cell(9'h001, 9'h000);
        check("tenth_illegal", 32'(illegal_move), 1);
        check("tenth_mc", 32'(move_count), 9);

        // board clear beats a same-cycle write, silently
        resetPosiciones = 1'b1;
        write_cell(9'h001, 9'h000);
        resetPosiciones = 1'b0;
        check("clrb_x", 32'(x), 0);
        check("clrb_o", 32'(o), 0);
        check("clrb_mc", 32'(move_count), 0);
        check("clrb_full", 32'(board_full), 0);
        check("clrb_illegal", 32'(illegal_move), 0);
        check("clrb_scores_kept", 32'(score_o), 1);

        write_cell(9'h000, 9'h100);
        check("post_clr_o", 32'(o), 32'h100);
        check("post_clr_mc", 32'(move_count), 1);

`ifdef TABLERO_UNDO_EN
        resetPosiciones = 1'b1; step(); resetPosiciones = 1'b0;
        write_cell(9'h001, 9'h000);
        write_cell(9'h000, 9'h100);
        check("undo_mc0", 32'(move_count), 2);
        deshacer = 1'b1; step(); deshacer = 1'b0;
        check("undo1_o", 32'(o), 0);
        check("undo1_x", 32'(x), 32'h001);
        check("undo1_mc", 32'(move_count), 1);
        deshacer = 1'b1; step(); deshacer = 1'b0;
        check("undo2_x", 32'(x), 0);
        check("undo2_mc", 32'(move_count), 0);
        check("undo2_illegal", 32'(illegal_move), 0);
        deshacer = 1'b1; step(); deshacer = 1'b0;
        check("undo3_mc", 32'(move_count), 0);
        check("undo3_illegal", 32'(illegal_move), 1);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
